// File: rtl/rsc_pkg.sv
// Shared constants and FSM encoding for the operand fetch stage and its scoreboard.
package rsc_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NREGS      = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } of_state_t;

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register busy tracking for in-flight destinations; optional sticky wb_err
// for unexpected writebacks when SCOREBOARD_ERR_EN is defined.
module operand_scoreboard #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  input  logic [ADDR_W-1:0] q_rd,
  output logic              busy_rs1,
  output logic              busy_rs2,
`ifdef SCOREBOARD_ERR_EN
  output logic              busy_rd,
  output logic              wb_err
`else
  output logic              busy_rd
`endif
);

  localparam int NR = 2 ** ADDR_W;

  logic [NR-1:0] r_busy;
  logic [NR-1:0] w_set_mask;
  logic [NR-1:0] w_clr_mask;
  logic [NR-1:0] w_busy_eff;

  // Register 0 is never tracked, so its busy bit stays 0 and queries on it never hazard.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en && (set_addr != '0)) w_set_mask[set_addr] = 1'b1;
    if (clr_en && (clr_addr != '0)) w_clr_mask[clr_addr] = 1'b1;
  end

  // A bit being retired this cycle is already written to the file, so it reads as free.
  assign w_busy_eff = r_busy & ~w_clr_mask;

  assign busy_rs1 = w_busy_eff[q_rs1];
  assign busy_rs2 = w_busy_eff[q_rs2];
  assign busy_rd  = w_busy_eff[q_rd];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

`ifdef SCOREBOARD_ERR_EN
  logic r_wb_err;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_wb_err <= 1'b0;
    end else if (clr_en && (clr_addr != '0) && !r_busy[clr_addr]) begin
      r_wb_err <= 1'b1;
    end
  end

  assign wb_err = r_wb_err;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Register-file initiator: issues reads, captures operands, hands them to execute,
// and forwards writeback to the file. SCOREBOARD_ERR_EN adds the sticky wb_err output.
module operand_fetch #(
  parameter int DATA_W = rsc_pkg::DATA_W,
  parameter int ADDR_W = rsc_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_wen,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_inaddr,
  output logic [DATA_W-1:0] rf_in,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [ADDR_W-1:0] ex_rd,
`ifdef SCOREBOARD_ERR_EN
  output logic              ex_wen,
  output logic              wb_err
`else
  output logic              ex_wen
`endif
);

  import rsc_pkg::*;

  of_state_t         r_state;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [ADDR_W-1:0] r_rd;
  logic              r_wen;
  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_op1;
  logic [DATA_W-1:0] r_ex_op2;
  logic [ADDR_W-1:0] r_ex_rd;
  logic              r_ex_wen;

  logic              w_busy_rs1;
  logic              w_busy_rs2;
  logic              w_busy_rd;
  logic              w_hazard;
  logic              w_id_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

  operand_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .clear_n  (clear_n),
    .set_en   (w_accept & id_wen),
    .set_addr (id_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_rd),
    .q_rs1    (id_rs1),
    .q_rs2    (id_rs2),
    .q_rd     (id_rd),
    .busy_rs1 (w_busy_rs1),
    .busy_rs2 (w_busy_rs2),
`ifdef SCOREBOARD_ERR_EN
    .busy_rd  (w_busy_rd),
    .wb_err   (wb_err)
`else
    .busy_rd  (w_busy_rd)
`endif
  );

  assign w_hazard   = w_busy_rs1 | w_busy_rs2 | (id_wen & w_busy_rd);
  assign w_id_ready = !w_hazard &&
                      ((r_state == ST_IDLE) || ((r_state == ST_VALID) && ex_ready));
  assign w_accept   = id_valid & w_id_ready;
  assign id_ready   = w_id_ready;

  // The file has one cycle of read latency, so addresses go out in the accept cycle.
  assign rf_addr1 = w_id_ready ? id_rs1 : r_rs1;
  assign rf_addr2 = w_id_ready ? id_rs2 : r_rs2;

  assign rf_write  = wb_valid && (wb_rd != '0);
  assign rf_inaddr = wb_rd;
  assign rf_in     = wb_data;

  // A writeback landing during READ is newer than what the file returned.
  always_comb begin
    w_op1 = rf_out1;
    w_op2 = rf_out2;
    if (r_rs1 == '0)                        w_op1 = '0;
    else if (wb_valid && (wb_rd == r_rs1))  w_op1 = wb_data;
    if (r_rs2 == '0)                        w_op2 = '0;
    else if (wb_valid && (wb_rd == r_rs2))  w_op2 = wb_data;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_IDLE;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_wen      <= 1'b0;
      r_ex_valid <= 1'b0;
      r_ex_op1   <= '0;
      r_ex_op2   <= '0;
      r_ex_rd    <= '0;
      r_ex_wen   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rs1   <= id_rs1;
            r_rs2   <= id_rs2;
            r_rd    <= id_rd;
            r_wen   <= id_wen;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_ex_op1   <= w_op1;
          r_ex_op2   <= w_op2;
          r_ex_rd    <= r_rd;
          r_ex_wen   <= r_wen;
          r_ex_valid <= 1'b1;
          r_state    <= ST_VALID;
        end
        ST_VALID: begin
          if (ex_ready) begin
            r_ex_valid <= 1'b0;
            if (w_accept) begin
              r_rs1   <= id_rs1;
              r_rs2   <= id_rs2;
              r_rd    <= id_rd;
              r_wen   <= id_wen;
              r_state <= ST_READ;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_op1   = r_ex_op1;
  assign ex_op2   = r_ex_op2;
  assign ex_rd    = r_ex_rd;
  assign ex_wen   = r_ex_wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 8x16 write-first register file.
// Build with SCOREBOARD_ERR_EN defined to also exercise wb_err.
module tb_operand_fetch;

  logic        clk;
  logic        clear_n;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_rs1, id_rs2, id_rd;
  logic        id_wen;
  logic [2:0]  rf_addr1, rf_addr2;
  logic [15:0] rf_out1, rf_out2;
  logic        rf_write;
  logic [2:0]  rf_inaddr;
  logic [15:0] rf_in;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_op1, ex_op2;
  logic [2:0]  ex_rd;
  logic        ex_wen;
`ifdef SCOREBOARD_ERR_EN
  logic        wb_err;
`endif

  int total = 0;
  int bad   = 0;

  operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rd     (id_rd),
    .id_wen    (id_wen),
    .rf_addr1  (rf_addr1),
    .rf_addr2  (rf_addr2),
    .rf_out1   (rf_out1),
    .rf_out2   (rf_out2),
    .rf_write  (rf_write),
    .rf_inaddr (rf_inaddr),
    .rf_in     (rf_in),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_op1    (ex_op1),
    .ex_op2    (ex_op2),
    .ex_rd     (ex_rd),
`ifdef SCOREBOARD_ERR_EN
    .ex_wen    (ex_wen),
    .wb_err    (wb_err)
`else
    .ex_wen    (ex_wen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: r0 reads 0, a write on the same edge is visible to the read.
  logic [15:0] mem [8] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (rf_write) mem[rf_inaddr] <= rf_in;
    rf_out1 <= (rf_addr1 == 3'd0) ? 16'h0 :
               (rf_write && rf_inaddr == rf_addr1) ? rf_in : mem[rf_addr1];
    rf_out2 <= (rf_addr2 == 3'd0) ? 16'h0 :
               (rf_write && rf_inaddr == rf_addr2) ? rf_in : mem[rf_addr2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [2:0] rd, input logic wen);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_wen = wen;
  endtask

  task automatic drive_wb(input logic v, input logic [2:0] rd, input logic [15:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    drive_wb(1'b0, 3'd0, 16'h0);
    ex_ready = 1'b1;
    tick(); tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b want=0", ex_valid); end
    total++; if (ex_wen !== 1'b0) begin bad++; $display("FAIL reset_ex_wen got=%b want=0", ex_wen); end
    total++; if (ex_op1 !== 16'h0 || ex_op2 !== 16'h0) begin bad++; $display("FAIL reset_ops got=%h/%h want=0000/0000", ex_op1, ex_op2); end
    total++; if (ex_rd !== 3'd0) begin bad++; $display("FAIL reset_ex_rd got=%0d want=0", ex_rd); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_id_ready got=%b want=1", id_ready); end
    clear_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive_wb(1'b1, 3'd1, 16'h1234);
    #1;
    total++; if (rf_write !== 1'b1 || rf_inaddr !== 3'd1 || rf_in !== 16'h1234) begin bad++;
      $display("FAIL basic_wb_port got=%b/%0d/%h want=1/1/1234", rf_write, rf_inaddr, rf_in); end
    tick();
    drive_wb(1'b0, 3'd0, 16'h0);
    drive_id(1'b1, 3'd1, 3'd0, 3'd4, 1'b0);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", id_ready); end
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b want=0", ex_valid); end
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", ex_valid); end
    total++; if (ex_op1 !== 16'h1234 || ex_op2 !== 16'h0000) begin bad++;
      $display("FAIL basic_ops got=%h/%h want=1234/0000", ex_op1, ex_op2); end
    total++; if (ex_rd !== 3'd4 || ex_wen !== 1'b0) begin bad++; $display("FAIL basic_rd got=%0d/%b want=4/0", ex_rd, ex_wen); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%b want=0", ex_valid); end
  endtask

  task automatic test_hazard();
    drive_id(1'b1, 3'd0, 3'd0, 3'd3, 1'b1);
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    tick();
    total++; if (ex_rd !== 3'd3 || ex_wen !== 1'b1) begin bad++; $display("FAIL hazard_dest got=%0d/%b want=3/1", ex_rd, ex_wen); end
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd3, 1'b1);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL hazard_waw got=%b want=0", id_ready); end
    drive_id(1'b0, 3'd0, 3'd0, 3'd3, 1'b0);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL hazard_nowen got=%b want=1", id_ready); end
    drive_id(1'b1, 3'd3, 3'd0, 3'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL hazard_raw_stall got=%b want=0", id_ready); end
      tick();
    end
    drive_wb(1'b1, 3'd3, 16'hBEEF);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL hazard_release got=%b want=1", id_ready); end
    tick();
    drive_wb(1'b0, 3'd0, 16'h0);
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    tick();
    total++; if (ex_valid !== 1'b1 || ex_op1 !== 16'hBEEF) begin bad++;
      $display("FAIL hazard_op1 got=%b/%h want=1/beef", ex_valid, ex_op1); end
    tick();
  endtask

  task automatic test_bypass();
    drive_id(1'b1, 3'd0, 3'd2, 3'd0, 1'b0);
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    drive_wb(1'b1, 3'd2, 16'h00AA);
    tick();
    drive_wb(1'b0, 3'd0, 16'h0);
    total++; if (ex_op2 !== 16'h00AA || ex_op1 !== 16'h0) begin bad++;
      $display("FAIL bypass_op2 got=%h/%h want=0000/00aa", ex_op1, ex_op2); end
    tick();
  endtask

  task automatic test_hold();
    ex_ready = 1'b0;
    drive_id(1'b1, 3'd1, 3'd2, 3'd6, 1'b0);
    tick();
    drive_id(1'b1, 3'd2, 3'd0, 3'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (ex_valid !== 1'b1 || ex_op1 !== 16'h1234 || ex_op2 !== 16'h00AA || ex_rd !== 3'd6) begin bad++;
        $display("FAIL hold_stable got=%b/%h/%h/%0d want=1/1234/00aa/6", ex_valid, ex_op1, ex_op2, ex_rd); end
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL hold_ready got=%b want=0", id_ready); end
      tick();
    end
    ex_ready = 1'b1;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", id_ready); end
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", ex_valid); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_op1 !== 16'h00AA || ex_op2 !== 16'h0 || ex_rd !== 3'd0) begin bad++;
      $display("FAIL b2b_ops got=%b/%h/%h/%0d want=1/00aa/0000/0", ex_valid, ex_op1, ex_op2, ex_rd); end
    tick();
  endtask

  task automatic test_r0();
    drive_wb(1'b1, 3'd0, 16'hFFFF);
    #1;
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL r0_write got=%b want=0", rf_write); end
    tick();
    drive_wb(1'b0, 3'd0, 16'h0);
    drive_id(1'b1, 3'd0, 3'd0, 3'd1, 1'b0);
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    drive_wb(1'b1, 3'd0, 16'hFFFF);
    tick();
    drive_wb(1'b0, 3'd0, 16'h0);
    total++; if (ex_op1 !== 16'h0 || ex_op2 !== 16'h0) begin bad++;
      $display("FAIL r0_read got=%h/%h want=0000/0000", ex_op1, ex_op2); end
    tick();
  endtask

  task automatic test_set_wins();
    drive_id(1'b1, 3'd0, 3'd0, 3'd4, 1'b1);
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    tick(); tick();
    drive_id(1'b1, 3'd0, 3'd0, 3'd4, 1'b1);
    drive_wb(1'b1, 3'd4, 16'h4444);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL setwin_ready got=%b want=1", id_ready); end
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    drive_wb(1'b0, 3'd0, 16'h0);
    tick(); tick();
    drive_id(1'b0, 3'd4, 3'd0, 3'd0, 1'b0);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL setwin_busy got=%b want=0", id_ready); end
    drive_wb(1'b1, 3'd4, 16'h5555);
    tick();
    drive_wb(1'b0, 3'd0, 16'h0);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL setwin_cleared got=%b want=1", id_ready); end
  endtask

  task automatic test_clear();
    drive_id(1'b1, 3'd1, 3'd0, 3'd7, 1'b1);
    tick();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    clear_n = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL clear_valid got=%b want=0", ex_valid); end
    tick();
    clear_n = 1'b1;
    tick(); tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL clear_dropped got=%b want=0", ex_valid); end
    drive_id(1'b0, 3'd7, 3'd0, 3'd7, 1'b1);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL clear_flushed got=%b want=1", id_ready); end
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

`ifdef SCOREBOARD_ERR_EN
  task automatic test_wb_err();
    #1;
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", wb_err); end
    drive_wb(1'b1, 3'd5, 16'h0505);
    tick();
    drive_wb(1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", wb_err); end
      tick();
    end
    clear_n = 1'b0;
    #1;
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL err_reset got=%b want=0", wb_err); end
    tick();
    clear_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_bypass();
    test_hold();
    test_r0();
    test_set_wins();
    test_clear();
`ifdef SCOREBOARD_ERR_EN
    test_wb_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
